snake_body_engine: RTL and testbench
====================================

SNAKE_BODY_ENGINE -- requirements
Module: snake_body_engine

Interface
REQ-001 The module SHALL have parameter MAX_LEN, default 8: maximum number of segments.
REQ-002 The module SHALL have parameter INIT_LEN, default 4: segment count after reset, range 1..MAX_LEN.
REQ-003 The module SHALL have parameters XDIM and YDIM, default 10 each: segment size in pixels.
REQ-004 The module SHALL have parameters XSCREEN and YSCREEN, default 160 and 120: screen size in pixels.
REQ-005 The module SHALL have parameters START_X and START_Y, default 80 and 60: head origin after reset.
REQ-006 The module SHALL have these ports, clock and reset first:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- step  in  1  one-cycle move request.
- dir  in  2  requested direction, type dir_t.
- grow  in  1  sampled with step: grow by one segment.
- x  out  8  pixel x.
- y  out  7  pixel y.
- plot  out  1  pixel write strobe.
- erase  out  1  when plot is high, 1 = background pixel and 0 = snake pixel.
- busy  out  1  move or initial draw in progress.
- done  out  1  one-cycle pulse when a move completes.
- dead  out  1  collision occurred; sticky.
- length  out  $clog2(MAX_LEN+1)  current segment count.

Function
REQ-007 Segment coordinates SHALL be held as MAX_LEN (x,y) pairs; index 0 is the head.
REQ-008 The FSM SHALL use these states: INIT_DRAW, IDLE, ERASE_TAIL, SHIFT, CHECK, DRAW_HEAD, DONE, DEAD.
REQ-009 INIT_DRAW SHALL plot all INIT_LEN segments tail-first, one pixel per cycle with erase=0, then go to IDLE.
REQ-010 In IDLE, step=1 SHALL latch dir and grow and go to ERASE_TAIL; if grow=1 and length<MAX_LEN, it SHALL go to SHIFT instead.
REQ-011 step SHALL be ignored in every state other than IDLE.
REQ-012 A latched dir that reverses the current direction SHALL be replaced by the current direction.
REQ-013 ERASE_TAIL and DRAW_HEAD SHALL each scan XDIM*YDIM pixels, x fastest, one per cycle, with plot=1.
- x = seg.x + xc; y = seg.y + yc.
REQ-014 SHIFT (1 cycle) SHALL do the following:
- seg[i] <= seg[i-1] for i = 1..MAX_LEN-1.
- seg[0] <= head moved by XDIM or YDIM in the latched direction.
- length increments when grow is accepted.
REQ-015 CHECK (1 cycle) SHALL go to DEAD if the new head lies outside x in [0, XSCREEN-XDIM] or y in [0, YSCREEN-YDIM]; otherwise it SHALL go to DRAW_HEAD.
REQ-016 Wall detection SHALL use a signed next-position comparison computed before SHIFT, so that moving left or up from 0 never wraps.
REQ-017 On a wall hit, the head register SHALL keep its previous value.
REQ-018 DONE SHALL pulse done for 1 cycle and return to IDLE.
- Move latency without growth: 2*XDIM*YDIM+3 cycles from step to done.
- Move latency with growth: XDIM*YDIM+3 cycles.
REQ-019 grow=1 when length==MAX_LEN SHALL be treated as a normal move.
REQ-020 DEAD SHALL hold plot=0, busy=0 and dead=1 until reset.
REQ-021 busy SHALL be 1 in every state except IDLE and DEAD.
REQ-022 Coordinate arithmetic SHALL be unsigned, 8-bit x and 7-bit y, with a 1-bit sign extension for the next-position check.

Reset
REQ-023 reset SHALL act at the clock edge and take priority over all other inputs, including mid-move.
REQ-024 While reset is asserted the outputs SHALL be:
- x=0, y=0, plot=0, erase=0, done=0, dead=0.
- busy=1.
- length=INIT_LEN.
REQ-025 On reset, seg[i] SHALL become (START_X - i*XDIM, START_Y), the current direction SHALL become RIGHT, and the state SHALL become INIT_DRAW.
REQ-026 Segments at index INIT_LEN and above SHALL be don't-care until shifted in.

Configuration
REQ-027 With SNAKE_SELF_COLLISION_EN defined, CHECK SHALL also go to DEAD when the new head equals any seg[1..length-1].
- When no growth occurs, the vacated tail SHALL be excluded from this check.
REQ-028 Without SNAKE_SELF_COLLISION_EN, only wall collisions SHALL set dead.

Structure
REQ-029 Package snake_pkg SHALL hold:
- typedef dir_t: RIGHT=0, DOWN=1, UP=2, LEFT=3.
- The FSM state enum.
- Default screen and segment constants.
REQ-030 Sub-module snake_seg_shift SHALL implement the MAX_LEN-deep coordinate shift register with reset preset values; the FSM and scan counters SHALL stay in the top module.

Verification (defaults)
REQ-031 The bench SHALL cover these directed scenarios:
- Reset, then release -> 400 plot pulses, tail segment (50,60) first, then busy=0, length=4.
- step, dir=RIGHT, grow=0 -> 100 erase pixels starting at (50,60), head becomes (90,60), 100 draw pixels, done 203 cycles after step.
- step, dir=LEFT while moving RIGHT -> treated as RIGHT, head becomes (100,60).
- Head at (150,60), step, dir=RIGHT -> dead=1, no DRAW_HEAD pixels, later steps ignored.
- length=8, step, grow=1 -> length stays 8 and the tail is erased; with length=4, grow=1 -> length=5, no erase, done after 103 cycles.
- SNAKE_SELF_COLLISION_EN defined, length 5, path RIGHT, DOWN, LEFT, UP -> dead=1; with the macro undefined the same stimulus -> dead=0.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg -- shared types and default geometry for the snake body engine.
//   dir_t    : movement direction (RIGHT=0, DOWN=1, UP=2, LEFT=3)
//   state_t  : engine FSM states
//   DEF_*    : default screen / segment geometry used as parameter defaults
//   is_reverse(): true when two directions are exact opposites
package snake_pkg;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    DOWN  = 2'd1,
    UP    = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    INIT_DRAW  = 3'd0,
    IDLE       = 3'd1,
    ERASE_TAIL = 3'd2,
    SHIFT      = 3'd3,
    CHECK      = 3'd4,
    DRAW_HEAD  = 3'd5,
    DONE       = 3'd6,
    DEAD       = 3'd7
  } state_t;

  localparam int DEF_MAX_LEN  = 8;
  localparam int DEF_INIT_LEN = 4;
  localparam int DEF_XDIM     = 10;
  localparam int DEF_YDIM     = 10;
  localparam int DEF_XSCREEN  = 160;
  localparam int DEF_YSCREEN  = 120;
  localparam int DEF_START_X  = 80;
  localparam int DEF_START_Y  = 60;

  // Opposite directions differ in both encoding bits (0<->3, 1<->2).
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return ((a ^ b) == 2'd3);
  endfunction

endpackage

// File: rtl/snake_seg_shift.sv
// snake_seg_shift -- MAX_LEN-deep (x,y) segment shift register; index 0 is the head.
// Ports:
//   clk, reset       : clock, synchronous active-high reset (presets the body
//                      to a horizontal line ending at START_X, heading right)
//   shift_en         : one-cycle shift; seg[i] <= seg[i-1], seg[0] <= head_x/head_y
//   head_x, head_y   : new head position loaded on shift
//   seg_x, seg_y     : all segment coordinates
module snake_seg_shift
  import snake_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int XDIM    = DEF_XDIM,
  parameter int START_X = DEF_START_X,
  parameter int START_Y = DEF_START_Y
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     shift_en,
  input  logic [7:0]               head_x,
  input  logic [6:0]               head_y,
  output logic [MAX_LEN-1:0][7:0]  seg_x,
  output logic [MAX_LEN-1:0][6:0]  seg_y
);

  logic [MAX_LEN-1:0][7:0] seg_x_r;
  logic [MAX_LEN-1:0][6:0] seg_y_r;

  // Segment storage: reset preset, then shift towards the tail on each move.
  // Entries past the initial length wrap arithmetically; they are never
  // plotted or compared until a real segment has been shifted in.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_r[i] <= 8'(START_X - i * XDIM);
        seg_y_r[i] <= 7'(START_Y);
      end
    end else if (shift_en) begin
      seg_x_r[0] <= head_x;
      seg_y_r[0] <= head_y;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_r[i] <= seg_x_r[i-1];
        seg_y_r[i] <= seg_y_r[i-1];
      end
    end
  end

  assign seg_x = seg_x_r;
  assign seg_y = seg_y_r;

endmodule

// File: rtl/snake_body_engine.sv
// snake_body_engine -- moves a segmented snake on a pixel screen and emits the
// pixel writes needed to redraw it (erase old tail, draw new head).
// Ports:
//   clk, reset   : 50 MHz clock, synchronous active-high reset
//   step         : one-cycle move request (honoured only when idle)
//   dir, grow    : direction and growth request sampled with step
//   x, y, plot   : pixel address and write strobe
//   erase        : with plot, 1 = background pixel, 0 = snake pixel
//   busy         : move or initial draw in progress
//   done         : one-cycle pulse at the end of a move
//   dead         : sticky collision flag
//   length       : current segment count
// Build option: define SNAKE_SELF_COLLISION_EN to also kill the snake when the
// new head lands on its own body.
// All outputs are registered: they are loaded from the values belonging to the
// state being entered, so they line up exactly with the state register.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = DEF_MAX_LEN,
  parameter int INIT_LEN = DEF_INIT_LEN,
  parameter int XDIM     = DEF_XDIM,
  parameter int YDIM     = DEF_YDIM,
  parameter int XSCREEN  = DEF_XSCREEN,
  parameter int YSCREEN  = DEF_YSCREEN,
  parameter int START_X  = DEF_START_X,
  parameter int START_Y  = DEF_START_Y
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            step,
  input  dir_t                            dir,
  input  logic                            grow,
  output logic [7:0]                      x,
  output logic [6:0]                      y,
  output logic                            plot,
  output logic                            erase,
  output logic                            busy,
  output logic                            done,
  output logic                            dead,
  output logic [$clog2(MAX_LEN+1)-1:0]    length
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [7:0]        XC_LAST    = 8'(XDIM - 1);
  localparam logic [6:0]        YC_LAST    = 7'(YDIM - 1);
  localparam logic signed [8:0] X_MAX      = 9'(XSCREEN - XDIM);
  localparam logic signed [7:0] Y_MAX      = 8'(YSCREEN - YDIM);
  localparam logic [LW-1:0]     INIT_LEN_C = LW'(INIT_LEN);
  localparam logic [LW-1:0]     MAX_LEN_C  = LW'(MAX_LEN);

  state_t                  state_r, state_nx_s;
  logic [7:0]              xc_r, xc_nx_s, adv_xc_s;
  logic [6:0]              yc_r, yc_nx_s, adv_yc_s;
  logic [LW-1:0]           idx_r, idx_nx_s;
  logic [LW-1:0]           length_r;
  dir_t                    cur_dir_r, dir_acc_s;
  logic                    grow_r, wall_r;
  logic                    last_px_s, grow_ok_s, wall_s, self_hit_s, shift_en_s;
  logic signed [8:0]       nx_s;
  logic signed [7:0]       ny_s;
  logic [MAX_LEN-1:0][7:0] seg_x_s;
  logic [MAX_LEN-1:0][6:0] seg_y_s;
  logic [LW-1:0]           sel_idx_s;
  logic [7:0]              sel_x_s, x_nx_s, x_r;
  logic [6:0]              sel_y_s, y_nx_s, y_r;
  logic                    plot_nx_s, erase_nx_s, busy_nx_s, done_nx_s, dead_nx_s;
  logic                    plot_r, erase_r, busy_r, done_r, dead_r;

  snake_seg_shift #(
    .MAX_LEN (MAX_LEN),
    .XDIM    (XDIM),
    .START_X (START_X),
    .START_Y (START_Y)
  ) u_seg (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en_s),
    .head_x   (nx_s[7:0]),
    .head_y   (ny_s[6:0]),
    .seg_x    (seg_x_s),
    .seg_y    (seg_y_s)
  );

  // A head never moves when it would leave the screen, so the body is frozen too.
  assign shift_en_s = (state_r == SHIFT) && !wall_s;
  assign grow_ok_s  = grow && (length_r < MAX_LEN_C);
  assign dir_acc_s  = is_reverse(dir, cur_dir_r) ? cur_dir_r : dir;

  // Candidate head position with one sign bit so that moving left/up from 0 goes negative.
  always_comb begin
    nx_s = {1'b0, seg_x_s[0]};
    ny_s = {1'b0, seg_y_s[0]};
    case (cur_dir_r)
      RIGHT:   nx_s = {1'b0, seg_x_s[0]} + 9'(XDIM);
      LEFT:    nx_s = {1'b0, seg_x_s[0]} - 9'(XDIM);
      DOWN:    ny_s = {1'b0, seg_y_s[0]} + 8'(YDIM);
      UP:      ny_s = {1'b0, seg_y_s[0]} - 8'(YDIM);
      default: nx_s = {1'b0, seg_x_s[0]};
    endcase
    wall_s = nx_s[8] || (nx_s > X_MAX) || ny_s[7] || (ny_s > Y_MAX);
  end

`ifdef SNAKE_SELF_COLLISION_EN
  // Head against body seg[1..length-1], evaluated after the shift; a non-growing
  // move has pushed the vacated tail to index length, so it is naturally excluded.
  always_comb begin
    self_hit_s = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      self_hit_s = self_hit_s | ((i < int'(length_r)) &&
                                 (seg_x_s[i] == seg_x_s[0]) &&
                                 (seg_y_s[i] == seg_y_s[0]));
    end
  end
`else
  assign self_hit_s = 1'b0;
`endif

  // Next pixel in a segment scan, x fastest.
  always_comb begin
    last_px_s = (xc_r == XC_LAST) && (yc_r == YC_LAST);
    if (xc_r == XC_LAST) begin
      adv_xc_s = 8'd0;
      adv_yc_s = yc_r + 7'd1;
    end else begin
      adv_xc_s = xc_r + 8'd1;
      adv_yc_s = yc_r;
    end
  end

  // FSM next state and scan counters. During INIT_DRAW the counters point at
  // the pixel currently shown; reset parks them one step before the first pixel.
  always_comb begin
    state_nx_s = state_r;
    xc_nx_s    = xc_r;
    yc_nx_s    = yc_r;
    idx_nx_s   = idx_r;
    case (state_r)
      INIT_DRAW: begin
        if (last_px_s) begin
          xc_nx_s = 8'd0;
          yc_nx_s = 7'd0;
          if (idx_r == LW'(0)) begin
            state_nx_s = IDLE;
          end else begin
            idx_nx_s = idx_r - LW'(1);
          end
        end else begin
          xc_nx_s = adv_xc_s;
          yc_nx_s = adv_yc_s;
        end
      end
      IDLE: begin
        if (step) begin
          xc_nx_s    = 8'd0;
          yc_nx_s    = 7'd0;
          state_nx_s = grow_ok_s ? SHIFT : ERASE_TAIL;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ERASE_TAIL: begin
        if (last_px_s) begin
          state_nx_s = SHIFT;
          xc_nx_s    = 8'd0;
          yc_nx_s    = 7'd0;
        end else begin
          xc_nx_s = adv_xc_s;
          yc_nx_s = adv_yc_s;
        end
      end
      SHIFT: state_nx_s = CHECK;
      CHECK: begin
        xc_nx_s = 8'd0;
        yc_nx_s = 7'd0;
        if (wall_r || self_hit_s) begin
          state_nx_s = DEAD;
        end else begin
          state_nx_s = DRAW_HEAD;
        end
      end
      DRAW_HEAD: begin
        if (last_px_s) begin
          state_nx_s = DONE;
          xc_nx_s    = 8'd0;
          yc_nx_s    = 7'd0;
        end else begin
          xc_nx_s = adv_xc_s;
          yc_nx_s = adv_yc_s;
        end
      end
      DONE:    state_nx_s = IDLE;
      DEAD:    state_nx_s = DEAD;
      default: state_nx_s = INIT_DRAW;
    endcase
  end

  // Output values for the state being entered; the segment base depends on the scan kind.
  always_comb begin
    case (state_nx_s)
      INIT_DRAW:  sel_idx_s = idx_nx_s;
      ERASE_TAIL: sel_idx_s = length_r - LW'(1);
      default:    sel_idx_s = LW'(0);
    endcase
    sel_x_s = 8'd0;
    sel_y_s = 7'd0;
    for (int i = 0; i < MAX_LEN; i++) begin
      sel_x_s = (int'(sel_idx_s) == i) ? seg_x_s[i] : sel_x_s;
      sel_y_s = (int'(sel_idx_s) == i) ? seg_y_s[i] : sel_y_s;
    end
    plot_nx_s  = (state_nx_s == INIT_DRAW) || (state_nx_s == ERASE_TAIL) ||
                 (state_nx_s == DRAW_HEAD);
    x_nx_s     = plot_nx_s ? (sel_x_s + xc_nx_s) : 8'd0;
    y_nx_s     = plot_nx_s ? (sel_y_s + yc_nx_s) : 7'd0;
    erase_nx_s = (state_nx_s == ERASE_TAIL);
    busy_nx_s  = (state_nx_s != IDLE) && (state_nx_s != DEAD);
    done_nx_s  = (state_nx_s == DONE);
    dead_nx_s  = (state_nx_s == DEAD);
  end

  // State, counters, latched move request, length and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= INIT_DRAW;
      xc_r      <= XC_LAST;
      yc_r      <= YC_LAST;
      idx_r     <= INIT_LEN_C;
      cur_dir_r <= RIGHT;
      grow_r    <= 1'b0;
      wall_r    <= 1'b0;
      length_r  <= INIT_LEN_C;
      x_r       <= 8'd0;
      y_r       <= 7'd0;
      plot_r    <= 1'b0;
      erase_r   <= 1'b0;
      busy_r    <= 1'b1;
      done_r    <= 1'b0;
      dead_r    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      xc_r    <= xc_nx_s;
      yc_r    <= yc_nx_s;
      idx_r   <= idx_nx_s;
      x_r     <= x_nx_s;
      y_r     <= y_nx_s;
      plot_r  <= plot_nx_s;
      erase_r <= erase_nx_s;
      busy_r  <= busy_nx_s;
      done_r  <= done_nx_s;
      dead_r  <= dead_nx_s;
      if ((state_r == IDLE) && step) begin
        cur_dir_r <= dir_acc_s;
        grow_r    <= grow_ok_s;
      end
      if (state_r == SHIFT) begin
        wall_r <= wall_s;
        if (grow_r && !wall_s) begin
          length_r <= length_r + LW'(1);
        end
      end
    end
  end

  assign x      = x_r;
  assign y      = y_r;
  assign plot   = plot_r;
  assign erase  = erase_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign dead   = dead_r;
  assign length = length_r;

endmodule

// File: tb/tb_snake_body_engine.sv
// tb_snake_body_engine -- directed self-checking bench for snake_body_engine
// with default parameters. Expected coordinates and latencies are hand-derived
// from the default geometry (10x10 segments, start head (80,60), length 4).
module tb_snake_body_engine;
  import snake_pkg::*;

  logic       clk;
  logic       reset;
  logic       step;
  dir_t       dir;
  logic       grow;
  logic [7:0] x;
  logic [6:0] y;
  logic       plot, erase, busy, done, dead;
  logic [3:0] length;

  int chk_cnt;
  int fail_cnt;

  snake_body_engine dut (
    .clk(clk), .reset(reset), .step(step), .dir(dir), .grow(grow),
    .x(x), .y(y), .plot(plot), .erase(erase), .busy(busy),
    .done(done), .dead(dead), .length(length)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reset, release and wait for the initial draw to finish (stimulus only).
  task automatic do_reset_init();
    int cyc;
    reset = 1'b1; step = 1'b0; grow = 1'b0; dir = RIGHT;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (busy && cyc < 2000);
    if (busy) begin
      $display("FAIL init_timeout: busy still 1 after %0d cycles, required 0", cyc);
      $fatal(1);
    end
  endtask

  // Issue one move and record pixel traffic until done or dead (bounded).
  // mid != 0 injects a step (dir=DOWN, grow=1) at that cycle of the move.
  task automatic run_move(input dir_t d, input logic g, input int mid,
                          output int cyc, output int n_er, output int n_dr,
                          output int ex0, output int ey0, output int dx0, output int dy0,
                          output logic fin);
    cyc = 0; n_er = 0; n_dr = 0; ex0 = -1; ey0 = -1; dx0 = -1; dy0 = -1; fin = 1'b0;
    @(negedge clk);
    step = 1'b1; dir = d; grow = g;
    while (!fin && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        step = 1'b0; grow = 1'b0;
      end
      if (mid != 0 && cyc == mid) begin
        step = 1'b1; dir = DOWN; grow = 1'b1;
      end
      if (mid != 0 && cyc == mid + 1) begin
        step = 1'b0; grow = 1'b0;
      end
      if (plot && erase) begin
        if (n_er == 0) begin ex0 = int'(x); ey0 = int'(y); end
        n_er++;
      end
      if (plot && !erase) begin
        if (n_dr == 0) begin dx0 = int'(x); dy0 = int'(y); end
        n_dr++;
      end
      if (done || dead) fin = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; step = 1'b0; grow = 1'b0; dir = RIGHT;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({x, y, plot, erase, done, dead} !== 19'd0) begin
      fail_cnt++; $display("FAIL reset_outputs: got %0h required 0", {x, y, plot, erase, done, dead});
    end
    chk_cnt++;
    if (busy !== 1'b1) begin fail_cnt++; $display("FAIL reset_busy: got %0b required 1", busy); end
    chk_cnt++;
    if (length !== 4'd4) begin fail_cnt++; $display("FAIL reset_length: got %0d required 4", length); end
  endtask

  task automatic test_init();
    int cyc, n, erc, fx, fy, lx, ly;
    cyc = 0; n = 0; erc = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    reset = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (plot) begin
        if (n == 0) begin fx = int'(x); fy = int'(y); end
        lx = int'(x); ly = int'(y);
        n++;
        if (erase) erc++;
      end
    end while (busy && cyc < 2000);
    chk_cnt++;
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL init_busy: got %0b required 0", busy); end
    chk_cnt++;
    if (n !== 400) begin fail_cnt++; $display("FAIL init_count: got %0d required 400", n); end
    chk_cnt++;
    if (fx !== 50 || fy !== 60) begin fail_cnt++; $display("FAIL init_first: got (%0d,%0d) required (50,60)", fx, fy); end
    chk_cnt++;
    if (lx !== 89 || ly !== 69) begin fail_cnt++; $display("FAIL init_last: got (%0d,%0d) required (89,69)", lx, ly); end
    chk_cnt++;
    if (erc !== 0) begin fail_cnt++; $display("FAIL init_erase: got %0d erase pixels required 0", erc); end
    chk_cnt++;
    if (length !== 4'd4) begin fail_cnt++; $display("FAIL init_length: got %0d required 4", length); end
  endtask

  // Plain move right; a step injected mid-move must be ignored.
  task automatic test_move_right();
    int cyc, ne, nd, ex, ey, dx, dy;
    logic fin;
    run_move(RIGHT, 1'b0, 50, cyc, ne, nd, ex, ey, dx, dy, fin);
    chk_cnt++;
    if (fin !== 1'b1 || cyc !== 203) begin fail_cnt++; $display("FAIL move_latency: got %0d (fin=%0b) required 203", cyc, fin); end
    chk_cnt++;
    if (ne !== 100 || ex !== 50 || ey !== 60) begin
      fail_cnt++; $display("FAIL move_erase: got %0d px from (%0d,%0d) required 100 from (50,60)", ne, ex, ey);
    end
    chk_cnt++;
    if (nd !== 100 || dx !== 90 || dy !== 60) begin
      fail_cnt++; $display("FAIL move_draw: got %0d px from (%0d,%0d) required 100 from (90,60)", nd, dx, dy);
    end
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b0 || busy !== 1'b0) begin fail_cnt++; $display("FAIL move_idle: got done=%0b busy=%0b required 0 0", done, busy); end
    chk_cnt++;
    if (length !== 4'd4) begin fail_cnt++; $display("FAIL move_length: got %0d required 4", length); end
  endtask

  task automatic test_reverse();
    int cyc, ne, nd, ex, ey, dx, dy;
    logic fin;
    run_move(LEFT, 1'b0, 0, cyc, ne, nd, ex, ey, dx, dy, fin);
    chk_cnt++;
    if (dx !== 100 || dy !== 60) begin fail_cnt++; $display("FAIL reverse_head: got (%0d,%0d) required (100,60)", dx, dy); end
    chk_cnt++;
    if (ex !== 60 || ey !== 60) begin fail_cnt++; $display("FAIL reverse_tail: got (%0d,%0d) required (60,60)", ex, ey); end
  endtask

  task automatic test_grow();
    int cyc, ne, nd, ex, ey, dx, dy;
    logic fin;
    run_move(RIGHT, 1'b1, 0, cyc, ne, nd, ex, ey, dx, dy, fin);
    chk_cnt++;
    if (fin !== 1'b1 || cyc !== 103) begin fail_cnt++; $display("FAIL grow_latency: got %0d (fin=%0b) required 103", cyc, fin); end
    chk_cnt++;
    if (ne !== 0) begin fail_cnt++; $display("FAIL grow_erase: got %0d required 0", ne); end
    chk_cnt++;
    if (dx !== 110 || dy !== 60 || nd !== 100) begin
      fail_cnt++; $display("FAIL grow_draw: got %0d px from (%0d,%0d) required 100 from (110,60)", nd, dx, dy);
    end
    chk_cnt++;
    if (length !== 4'd5) begin fail_cnt++; $display("FAIL grow_length: got %0d required 5", length); end
  endtask

  // Reset in the middle of a move wins over everything.
  task automatic test_reset_mid_move();
    @(negedge clk);
    step = 1'b1; dir = DOWN; grow = 1'b0;
    @(negedge clk);
    step = 1'b0;
    repeat (40) @(negedge clk);
    chk_cnt++;
    if (plot !== 1'b1 || erase !== 1'b1) begin fail_cnt++; $display("FAIL midmove_erasing: got plot=%0b erase=%0b required 1 1", plot, erase); end
    reset = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (plot !== 1'b0 || busy !== 1'b1 || x !== 8'd0) begin
      fail_cnt++; $display("FAIL midmove_reset: got plot=%0b busy=%0b x=%0d required 0 1 0", plot, busy, x);
    end
    chk_cnt++;
    if (length !== 4'd4) begin fail_cnt++; $display("FAIL midmove_length: got %0d required 4", length); end
  endtask

  task automatic test_full_grow();
    int cyc, ne, nd, ex, ey, dx, dy;
    logic fin;
    do_reset_init();
    for (int k = 0; k < 4; k++) begin
      run_move(RIGHT, 1'b1, 0, cyc, ne, nd, ex, ey, dx, dy, fin);
    end
    chk_cnt++;
    if (length !== 4'd8 || dx !== 120) begin fail_cnt++; $display("FAIL full_setup: got len=%0d head_x=%0d required 8 120", length, dx); end
    run_move(RIGHT, 1'b1, 0, cyc, ne, nd, ex, ey, dx, dy, fin);
    chk_cnt++;
    if (fin !== 1'b1 || cyc !== 203) begin fail_cnt++; $display("FAIL full_latency: got %0d required 203", cyc); end
    chk_cnt++;
    if (ne !== 100 || ex !== 50 || ey !== 60) begin
      fail_cnt++; $display("FAIL full_erase: got %0d px from (%0d,%0d) required 100 from (50,60)", ne, ex, ey);
    end
    chk_cnt++;
    if (length !== 4'd8 || dx !== 130) begin fail_cnt++; $display("FAIL full_length: got len=%0d head_x=%0d required 8 130", length, dx); end
  endtask

  task automatic test_wall();
    int cyc, ne, nd, ex, ey, dx, dy, np, nb;
    logic fin;
    do_reset_init();
    for (int k = 0; k < 7; k++) begin
      run_move(RIGHT, 1'b0, 0, cyc, ne, nd, ex, ey, dx, dy, fin);
    end
    chk_cnt++;
    if (dx !== 150 || dead !== 1'b0) begin fail_cnt++; $display("FAIL wall_setup: got head_x=%0d dead=%0b required 150 0", dx, dead); end
    run_move(RIGHT, 1'b0, 0, cyc, ne, nd, ex, ey, dx, dy, fin);
    chk_cnt++;
    if (dead !== 1'b1 || cyc !== 103) begin fail_cnt++; $display("FAIL wall_dead: got dead=%0b at %0d required 1 at 103", dead, cyc); end
    chk_cnt++;
    if (nd !== 0 || ne !== 100) begin fail_cnt++; $display("FAIL wall_pixels: got draw=%0d erase=%0d required 0 100", nd, ne); end
    chk_cnt++;
    if (busy !== 1'b0 || plot !== 1'b0) begin fail_cnt++; $display("FAIL wall_outputs: got busy=%0b plot=%0b required 0 0", busy, plot); end
    np = 0; nb = 0;
    @(negedge clk);
    step = 1'b1; dir = DOWN; grow = 1'b1;
    @(negedge clk);
    step = 1'b0; grow = 1'b0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if (plot) np++;
      if (busy) nb++;
    end
    chk_cnt++;
    if (np !== 0 || nb !== 0 || dead !== 1'b1) begin
      fail_cnt++; $display("FAIL dead_ignore: got plots=%0d busy=%0d dead=%0b required 0 0 1", np, nb, dead);
    end
  endtask

  task automatic test_self_collision();
    int cyc, ne, nd, ex, ey, dx, dy;
    logic fin;
    do_reset_init();
    run_move(RIGHT, 1'b1, 0, cyc, ne, nd, ex, ey, dx, dy, fin);
    run_move(DOWN, 1'b0, 0, cyc, ne, nd, ex, ey, dx, dy, fin);
    chk_cnt++;
    if (dx !== 90 || dy !== 70) begin fail_cnt++; $display("FAIL self_down: got (%0d,%0d) required (90,70)", dx, dy); end
    run_move(LEFT, 1'b0, 0, cyc, ne, nd, ex, ey, dx, dy, fin);
    chk_cnt++;
    if (dx !== 80 || dy !== 70) begin fail_cnt++; $display("FAIL self_left: got (%0d,%0d) required (80,70)", dx, dy); end
    run_move(UP, 1'b0, 0, cyc, ne, nd, ex, ey, dx, dy, fin);
`ifdef SNAKE_SELF_COLLISION_EN
    chk_cnt++;
    if (dead !== 1'b1 || nd !== 0) begin fail_cnt++; $display("FAIL self_hit: got dead=%0b draw=%0d required 1 0", dead, nd); end
`else
    chk_cnt++;
    if (dead !== 1'b0 || cyc !== 203) begin fail_cnt++; $display("FAIL self_nohit: got dead=%0b at %0d required 0 at 203", dead, cyc); end
    chk_cnt++;
    if (dx !== 80 || dy !== 60) begin fail_cnt++; $display("FAIL self_up: got (%0d,%0d) required (80,60)", dx, dy); end
`endif
  endtask

  initial begin
    chk_cnt = 0;
    fail_cnt = 0;
    reset = 1'b1; step = 1'b0; grow = 1'b0; dir = RIGHT;
    test_reset();
    test_init();
    test_move_right();
    test_reverse();
    test_grow();
    test_reset_mid_move();
    test_full_grow();
    test_wall();
    test_self_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
